// File: rtl/icache_line_filler_pkg.sv
// Shared types and helpers for the instruction-cache line filler.
// Cache geometry: 32 lines x 16 bytes, 9-bit RAM address.
package icache_line_filler_pkg;

  localparam int LINE_BYTES = 16;
  localparam int NUM_LINES  = 32;
  localparam int CACHE_AW   = 9;
  localparam int MAX_AW     = 32;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FINISH
  } state_e;

  // Callers truncate the result to their address width, giving mod-2^W wrap.
  function automatic logic [MAX_AW-1:0] line_addr(
    input logic [MAX_AW-1:0] cbr,
    input logic [4:0]        line
  );
    return (cbr & ~MAX_AW'(4'hF)) + (MAX_AW'(line) << 4);
  endfunction

endpackage

// File: rtl/icache_line_filler.sv
// Instruction-cache fill engine: fetches a 16-byte line into cache RAM
// on a miss and owns the per-line valid bits.
module icache_line_filler
  import icache_line_filler_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [4:0]           req_line,
  input  logic [ADDR_W-1:0]    cbr,
  input  logic                 flush,
  output logic [NUM_LINES-1:0] line_valid,
  output logic                 done,
  output logic                 mem_req,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic                 mem_ack,
  input  logic [7:0]           mem_data,
  output logic                 cache_we,
  output logic [CACHE_AW-1:0]  cache_waddr,
  output logic [7:0]           cache_wdata
);

  localparam logic [3:0] LAST = 4'(LINE_BYTES - 1);

  state_e                state_q, state_d;
  logic [4:0]            line_q, line_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [NUM_LINES-1:0]  valid_q, valid_d;
  logic                  done_q, done_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic                  we_q, we_d;
  logic [CACHE_AW-1:0]   waddr_q, waddr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic [3:0]            nxt_cnt;

  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    mem_req_d  = 1'b0;
    mem_addr_d = mem_addr_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    nxt_cnt    = cnt_q + 4'd1;
    // Flush outranks everything, including an ack or request this cycle.
    if (flush) begin
      state_d = IDLE;
      valid_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (valid_q[req_line]) begin
              done_d = 1'b1;
            end else begin
              line_d     = req_line;
              base_d     = ADDR_W'(line_addr(MAX_AW'(cbr), req_line));
              cnt_d      = 4'd0;
              mem_addr_d = base_d;
              mem_req_d  = 1'b1;
              state_d    = FILL;
            end
          end
        end
        FILL: begin
          mem_req_d = 1'b1;
          if (mem_ack) begin
            we_d       = 1'b1;
            waddr_d    = {line_q, cnt_q};
            wdata_d    = mem_data;
            cnt_d      = nxt_cnt;
            mem_addr_d = base_q + ADDR_W'(nxt_cnt);
            if (cnt_q == LAST) begin
              mem_req_d       = 1'b0;
              done_d          = 1'b1;
              valid_d[line_q] = 1'b1;
              state_d         = FINISH;
            end
          end
        end
        FINISH:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      line_q     <= '0;
      base_q     <= '0;
      cnt_q      <= '0;
      valid_q    <= '0;
      done_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign line_valid  = valid_q;
  assign done        = done_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign cache_we    = we_q;
  assign cache_waddr = waddr_q;
  assign cache_wdata = wdata_q;

endmodule
